// File: rtl/shift_pkg.sv
// Shared types and constants for the PISO transmitter and its bit counter.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_t;

  localparam bit SHIFT_MSB_FIRST = 1'b1;
  localparam bit SHIFT_LSB_FIRST = 1'b0;

  localparam int unsigned SHIFT_DEFAULT_WIDTH = 4;
  localparam int unsigned SHIFT_CNT_W         = $clog2(SHIFT_DEFAULT_WIDTH);

  function automatic int unsigned shift_cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_piso_transmitter_if.sv
// Load-side valid/ready handshake between a word producer and the transmitter.
interface shift_piso_transmitter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] parallel_in;
  logic             load_valid;
  logic             load_ready;

  modport master (output parallel_in, output load_valid, input load_ready);
  modport slave  (input parallel_in, input load_valid, output load_ready);
endinterface

// File: rtl/shift_bit_counter.sv
// Frame bit index: cleared on start, advanced on enable, saturates at WIDTH-1.
module shift_bit_counter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_DEFAULT_WIDTH
) (
  input  logic                              clk,
  input  logic                              clear,
  input  logic                              start,
  input  logic                              enable,
  output logic [shift_cnt_width(WIDTH)-1:0] count,
  output logic                              last
);
  localparam int unsigned CW = shift_cnt_width(WIDTH);
  localparam logic [CW-1:0] TERMINAL = CW'(WIDTH - 1);

  assign last = (count == TERMINAL);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (enable && !last) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/shift_piso_transmitter.sv
// Parallel-in serial-out transmitter with valid/ready load and gapless framing.
module shift_piso_transmitter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH      = SHIFT_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST  = SHIFT_MSB_FIRST,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                            clk,
  input  logic                            clear,
  shift_piso_transmitter_if.slave         load_if,
  output logic                            serial_out,
  output logic                            frame_active,
  output logic                            frame_done
);
  localparam int unsigned CW = shift_cnt_width(WIDTH);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  shift_state_t     state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             serial_next, active_next, done_next;
  logic             start, enable, last, accept;
  logic [CW-1:0]    count;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST == SHIFT_MSB_FIRST) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST == SHIFT_MSB_FIRST) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign load_if.load_ready = !clear && ((state == IDLE) || (state == SHIFT && last));
  assign accept             = load_if.load_valid && load_if.load_ready;

  shift_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .clear  (clear),
    .start  (start),
    .enable (enable),
    .count  (count),
    .last   (last)
  );

  // serial_out is registered, so the word's head bit goes straight to the
  // output on acceptance and the shift register holds only the remaining bits.
  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    serial_next = serial_out;
    active_next = frame_active;
    done_next   = 1'b0;
    start       = 1'b0;
    enable      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next  = SHIFT;
          start       = 1'b1;
          serial_next = head_bit(load_if.parallel_in);
          shreg_next  = advance(load_if.parallel_in);
          active_next = 1'b1;
        end
      end
      SHIFT: begin
        if (!last) begin
          enable      = 1'b1;
          serial_next = head_bit(shreg);
          shreg_next  = advance(shreg);
          done_next   = (count == PENULT);
        end else if (accept) begin
          start       = 1'b1;
          serial_next = head_bit(load_if.parallel_in);
          shreg_next  = advance(load_if.parallel_in);
          active_next = 1'b1;
        end else begin
          state_next  = IDLE;
          serial_next = IDLE_LEVEL;
          active_next = 1'b0;
        end
      end
      default: begin
        state_next  = IDLE;
        serial_next = IDLE_LEVEL;
        active_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= IDLE;
      shreg        <= '0;
      serial_out   <= IDLE_LEVEL;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_next;
      shreg        <= shreg_next;
      serial_out   <= serial_next;
      frame_active <= active_next;
      frame_done   <= done_next;
    end
  end
endmodule
